w4a8_gemm_counter_bank: RTL
===========================

Name: w4a8_gemm_counter_bank

Overview:
- Bank of C_NUM_CH independent up/down counters with per-channel variable step sizes.
- Used by the GEMM control path to track:
  - outstanding AXI read/write beats (credits),
  - tile/row loop indices,
  - output-buffer occupancy.
- Extends the basic single load/incr/decr counter with three additions: multi-step increments and decrements in the same cycle, a selectable saturate or wrap mode, and registered max flags plus sticky overflow/underflow flags.
- Instantiated inside the kernel control block, in the ap_clk domain.

Parameters:
- C_WIDTH, 8, counter width per channel (2..32).
- C_NUM_CH, 4, number of channels (1..16).
- C_STEP_WIDTH, 4, width of each incr/decr step operand (1..C_WIDTH).
- C_INIT, 0, reset value of every channel, C_WIDTH bits.
- C_SATURATE, 1, 1 = clamp to [0, 2^C_WIDTH-1]; 0 = wrap modulo 2^C_WIDTH.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous active-low reset.
- clken  in  1  global clock enable; when low, all state holds.
- load  in  C_NUM_CH  per-channel load strobe.
- load_value  in  C_NUM_CH*C_WIDTH  load data; channel i occupies bits [i*C_WIDTH +: C_WIDTH].
- incr  in  C_NUM_CH  per-channel increment strobe.
- incr_step  in  C_NUM_CH*C_STEP_WIDTH  increment amount, packed the same way as load_value.
- decr  in  C_NUM_CH  per-channel decrement strobe.
- decr_step  in  C_NUM_CH*C_STEP_WIDTH  decrement amount.
- clr_sticky  in  C_NUM_CH  clears the ovf/unf sticky flags of the channel.
- count  out  C_NUM_CH*C_WIDTH  registered count.
- is_zero  out  C_NUM_CH  registered; count == 0.
- is_max  out  C_NUM_CH  registered; count == 2^C_WIDTH-1.
- ovf_sticky  out  C_NUM_CH  set on any overflow event.
- unf_sticky  out  C_NUM_CH  set on any underflow event.
- all_zero  out  1  AND of is_zero (combinational from registers).
- any_zero  out  1  OR of is_zero.

Behaviour:
- Reset, sampled when ap_rst_n = 0 at a posedge, has priority over clken:
  - count = C_INIT;
  - is_zero = (C_INIT == 0);
  - is_max = (C_INIT == all-ones);
  - both stickies = 0.
- clken = 0: every register holds, including stickies; clr_sticky is ignored.
- Per channel, with clken = 1, priority is load > incr/decr:
  - load = 1: count <= load_value. incr/decr are ignored. Stickies are unchanged (apart from clr_sticky).
  - Otherwise compute raw = count + (incr ? incr_step : 0) - (decr ? decr_step : 0) in signed C_WIDTH+2 bits. Step operands are zero-extended.
  - Simultaneous incr and decr are netted in that single expression.
- Overflow event: raw > 2^C_WIDTH-1. Underflow event: raw < 0. Both are evaluated only when load = 0.
- C_SATURATE = 1: count <= clamp(raw, 0, 2^C_WIDTH-1).
- C_SATURATE = 0: count <= raw mod 2^C_WIDTH.
- Sticky flags are set on events in both modes.
- Sticky update: sticky <= (sticky & ~clr_sticky) | event. If a clear and a new event happen in the same cycle, the set wins.
- incr with step 0 is a no-op. incr and decr with equal steps leave count unchanged and raise no event.
- Latency: one cycle from strobe to count, is_zero, is_max and stickies.
  - is_zero and is_max are computed from the next-count value and registered together with count. They are never one cycle stale.
- all_zero and any_zero are pure combinational reductions of the registered is_zero; no extra latency.
- Channels are fully independent. There is no cross-channel interaction other than the all_zero/any_zero reductions.
- No X propagation: step inputs are don't-care when their strobe is low, and must not affect state.

Decomposition:
- Package w4a8_gemm_counter_pkg holds:
  - the saturate/wrap localparam encodings;
  - a function computing next-count plus event flags (shared by RTL and the scoreboard model).
- Sub-module w4a8_gemm_counter_lane implements one channel: count, is_zero, is_max and the two stickies.
- The bank is a generate loop over lanes plus the all/any reductions.

Test Plan:
- Reset, C_INIT = 0, W = 8 → count = 0, is_zero = 1, is_max = 0, all_zero = 1, stickies = 0. Then assert load on ch0 with load_value = 0xFF → next cycle count0 = 0xFF, is_max0 = 1, all_zero = 0, any_zero = 1.
- Saturate, ch1 = 0xFC, incr_step = 7 → count1 = 0xFF, ovf_sticky1 = 1. Then pulse clr_sticky1 → 0. Then decr_step = 15 from count 3 → count1 = 0, unf_sticky1 = 1, is_zero1 = 1.
- Wrap (C_SATURATE = 0), count = 0xFE, incr_step = 3 → count = 0x01, ovf_sticky = 1, is_zero = 0. Then decr_step = 2 → count = 0xFF, unf_sticky = 1.
- Netting: count = 10, incr_step = 5 with decr_step = 3 in the same cycle → 12, no events. Then incr_step = 4 with decr_step = 4 → stays 12.
- Priority: load = 1 together with incr/decr and a would-be overflow → count = load_value, no sticky set. Then clr_sticky in the same cycle as an overflow event → sticky remains 1.
- Hold and reset: clken = 0 with all strobes active for 3 cycles → no change at all. Then deassert ap_rst_n mid-operation with clken = 0 → all channels return to the C_INIT state on the next posedge.

Source files
------------

// File: rtl/w4a8_gemm_counter_bank_pkg.sv
// w4a8_gemm_counter_pkg: mode encodings and the shared next-count/event function
// cnt_step(cnt, inc, dec, w, sat) -> {nxt, ovf, unf}; operands are zero-extended to C_MAX_W
package w4a8_gemm_counter_pkg;
  localparam bit C_MODE_WRAP = 1'b0;
  localparam bit C_MODE_SAT = 1'b1;
  localparam int C_MAX_W = 32;
  typedef struct packed {
    logic [C_MAX_W-1:0] nxt;
    logic               ovf;
    logic               unf;
  } step_res_t;
  // Two guard bits hold both cnt+inc (no carry loss) and the sign of cnt-dec
  function automatic step_res_t cnt_step(
    input logic [C_MAX_W-1:0] cnt,
    input logic [C_MAX_W-1:0] inc,
    input logic [C_MAX_W-1:0] dec,
    input int unsigned        w,
    input bit                 sat
  );
    logic signed [C_MAX_W+1:0] raw;
    logic signed [C_MAX_W+1:0] lim;
    step_res_t r;
    lim = (34'sd1 <<< w) - 34'sd1;
    raw = $signed({2'b00, cnt}) + $signed({2'b00, inc}) - $signed({2'b00, dec});
    r.ovf = raw > lim;
    r.unf = raw < 34'sd0;
    r.nxt = sat ? (r.ovf ? lim[C_MAX_W-1:0] : r.unf ? '0 : raw[C_MAX_W-1:0])
                : raw[C_MAX_W-1:0] & lim[C_MAX_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/w4a8_gemm_counter_bank_if.sv
// w4a8_gemm_counter_bank_if: strobes/steps in, counts and flags out
// master drives load/incr/decr/clr_sticky/clken, slave (the bank) drives count and flags
interface w4a8_gemm_counter_bank_if #(
  parameter int C_WIDTH      = 8,
  parameter int C_NUM_CH     = 4,
  parameter int C_STEP_WIDTH = 4
);
  logic                           clken;
  logic [C_NUM_CH-1:0]            load;
  logic [C_NUM_CH*C_WIDTH-1:0]    load_value;
  logic [C_NUM_CH-1:0]            incr;
  logic [C_NUM_CH*C_STEP_WIDTH-1:0] incr_step;
  logic [C_NUM_CH-1:0]            decr;
  logic [C_NUM_CH*C_STEP_WIDTH-1:0] decr_step;
  logic [C_NUM_CH-1:0]            clr_sticky;
  logic [C_NUM_CH*C_WIDTH-1:0]    count;
  logic [C_NUM_CH-1:0]            is_zero;
  logic [C_NUM_CH-1:0]            is_max;
  logic [C_NUM_CH-1:0]            ovf_sticky;
  logic [C_NUM_CH-1:0]            unf_sticky;
  logic                           all_zero;
  logic                           any_zero;
  modport master (
    output clken, load, load_value, incr, incr_step, decr, decr_step, clr_sticky,
    input  count, is_zero, is_max, ovf_sticky, unf_sticky, all_zero, any_zero
  );
  modport slave (
    input  clken, load, load_value, incr, incr_step, decr, decr_step, clr_sticky,
    output count, is_zero, is_max, ovf_sticky, unf_sticky, all_zero, any_zero
  );
endinterface

// File: rtl/w4a8_gemm_counter_lane.sv
// w4a8_gemm_counter_lane: one up/down counter channel with max/zero flags and ovf/unf stickies
// in: ap_clk, ap_rst_n, clken_i, load_i/load_value_i, incr_i/incr_step_i, decr_i/decr_step_i, clr_sticky_i
// out: count_o, is_zero_o, is_max_o, ovf_o, unf_o (all registered)
module w4a8_gemm_counter_lane
  import w4a8_gemm_counter_pkg::*;
#(
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_STEP_WIDTH = 4,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0,
  parameter bit                 C_SATURATE   = C_MODE_SAT
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    clken_i,
  input  logic                    load_i,
  input  logic [C_WIDTH-1:0]      load_value_i,
  input  logic                    incr_i,
  input  logic [C_STEP_WIDTH-1:0] incr_step_i,
  input  logic                    decr_i,
  input  logic [C_STEP_WIDTH-1:0] decr_step_i,
  input  logic                    clr_sticky_i,
  output logic [C_WIDTH-1:0]      count_o,
  output logic                    is_zero_o,
  output logic                    is_max_o,
  output logic                    ovf_o,
  output logic                    unf_o
);
  logic [C_WIDTH-1:0] count_q, count_d;
  logic zero_q, max_q, ovf_q, unf_q, ovf_d, unf_d;
  step_res_t res;
  // Gating the steps by their strobes keeps undriven step inputs out of the state
  always_comb begin
    res = cnt_step(C_MAX_W'(count_q), incr_i ? C_MAX_W'(incr_step_i) : '0,
                   decr_i ? C_MAX_W'(decr_step_i) : '0, C_WIDTH, C_SATURATE);
    count_d = load_i ? load_value_i : C_WIDTH'(res.nxt);
    ovf_d = (ovf_q & ~clr_sticky_i) | (~load_i & res.ovf);
    unf_d = (unf_q & ~clr_sticky_i) | (~load_i & res.unf);
  end
  // Flags derive from count_d so they land in the same cycle as the count
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count_q <= C_INIT;
      zero_q  <= C_INIT == '0;
      max_q   <= &C_INIT;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clken_i) begin
      count_q <= count_d;
      zero_q  <= count_d == '0;
      max_q   <= &count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign count_o   = count_q;
  assign is_zero_o = zero_q;
  assign is_max_o  = max_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;
endmodule

// File: rtl/w4a8_gemm_counter_bank.sv
// w4a8_gemm_counter_bank: C_NUM_CH independent step counters plus all/any-zero reductions
// in: ap_clk, ap_rst_n (sync, active-low); bus: slave side of w4a8_gemm_counter_bank_if
module w4a8_gemm_counter_bank
  import w4a8_gemm_counter_pkg::*;
#(
  parameter int                 C_WIDTH      = 8,
  parameter int                 C_NUM_CH     = 4,
  parameter int                 C_STEP_WIDTH = 4,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0,
  parameter bit                 C_SATURATE   = C_MODE_SAT
) (
  input logic                     ap_clk,
  input logic                     ap_rst_n,
  w4a8_gemm_counter_bank_if.slave bus
);
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_lane
    w4a8_gemm_counter_lane #(
      .C_WIDTH(C_WIDTH), .C_STEP_WIDTH(C_STEP_WIDTH), .C_INIT(C_INIT), .C_SATURATE(C_SATURATE)
    ) u_lane (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .clken_i     (bus.clken),
      .load_i      (bus.load[i]),
      .load_value_i(bus.load_value[i*C_WIDTH +: C_WIDTH]),
      .incr_i      (bus.incr[i]),
      .incr_step_i (bus.incr_step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .decr_i      (bus.decr[i]),
      .decr_step_i (bus.decr_step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
      .clr_sticky_i(bus.clr_sticky[i]),
      .count_o     (bus.count[i*C_WIDTH +: C_WIDTH]),
      .is_zero_o   (bus.is_zero[i]),
      .is_max_o    (bus.is_max[i]),
      .ovf_o       (bus.ovf_sticky[i]),
      .unf_o       (bus.unf_sticky[i])
    );
  end
  assign bus.all_zero = &bus.is_zero;
  assign bus.any_zero = |bus.is_zero;
endmodule
